uncache_data_bridge: RTL



---
 rtl/uncache_data_bridge_if.sv | 21 ++
 rtl/uncache_data_bridge.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uncache_data_bridge_if.sv
// Single-beat uncached bus: the bridge is the master, the uncached memory port is the slave.
interface uncache_data_bridge_if;
  logic        ucb_req;
  logic        ucb_wr;
  logic [31:0] ucb_addr;
  logic [31:0] ucb_wdata;
  logic [3:0]  ucb_wstrb;
  logic        ucb_addr_ok;
  logic        ucb_data_ok;
  logic [31:0] ucb_rdata;

  modport master (
    output ucb_req, ucb_wr, ucb_addr, ucb_wdata, ucb_wstrb,
    input  ucb_addr_ok, ucb_data_ok, ucb_rdata
  );

  modport slave (
    input  ucb_req, ucb_wr, ucb_addr, ucb_wdata, ucb_wstrb,
    output ucb_addr_ok, ucb_data_ok, ucb_rdata
  );
endinterface

// File: rtl/uncache_data_bridge.sv
// Uncached MEM-stage bridge: posted store buffer drained one write at a time, and blocking
// single-beat loads that wait for the buffer to empty; stores stall only when the buffer is full.
module uncache_data_bridge #(
  parameter int SB_DEPTH = 4
) (
  input  logic                 core_clk,
  input  logic                 rst,
  input  logic                 MEM_Valid,
  input  logic                 MEM_ReadMem,
  input  logic                 MEM_WriteMem,
  input  logic                 MEM_Flush,
  input  logic [31:0]          Phsy_Daddr,
  input  logic                 D_IsCached,
  input  logic                 D_IsTLBException,
  input  logic [31:0]          MEM_WrData,
  input  logic [3:0]           MEM_ByteEn,
  uncache_data_bridge_if.master ucb,
  output logic                 UC_Stall,
  output logic                 UC_RdValid,
  output logic [31:0]          UC_RdData
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] SB_FULL = CW'(SB_DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } sb_ent_t;

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} w_state_e;
  typedef enum logic [2:0] {RD_IDLE, RD_REQ, RD_WAIT, RD_DONE, RD_DISCARD} rd_state_e;

  sb_ent_t       sb_mem_q [SB_DEPTH];
  sb_ent_t       head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  w_state_e      w_q, w_d;
  rd_state_e     rd_q, rd_d;
  logic [31:0]   ld_addr_q, ld_addr_d;
  logic [3:0]    ld_be_q, ld_be_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          presented, pres_ld, pres_st, sb_full, enq, pop;

  assign presented = MEM_Valid & ~D_IsCached & ~D_IsTLBException & ~MEM_Flush
                   & (MEM_ReadMem | MEM_WriteMem);
  assign pres_ld   = presented & MEM_ReadMem;
  assign pres_st   = presented & MEM_WriteMem & ~MEM_ReadMem;
  // Full check uses the registered count, so a pop frees the slot only on the next cycle.
  assign sb_full   = (cnt_q == SB_FULL);
  assign enq       = pres_st & ~sb_full;
  assign pop       = (w_q == W_WAIT) & ucb.ucb_data_ok;
  assign head      = sb_mem_q[rd_ptr_q];

  assign UC_Stall   = (pres_st & sb_full) | (pres_ld & (rd_q != RD_DONE));
  assign UC_RdValid = (rd_q == RD_DONE);
  assign UC_RdData  = rdata_q;

  always_ff @(posedge core_clk) begin
    if (enq) sb_mem_q[wr_ptr_q] <= '{addr: Phsy_Daddr, wdata: MEM_WrData, wstrb: MEM_ByteEn};
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      w_q       <= W_IDLE;
      rd_q      <= RD_IDLE;
      ld_addr_q <= '0;
      ld_be_q   <= '0;
      rdata_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      rd_q      <= rd_d;
      ld_addr_q <= ld_addr_d;
      ld_be_q   <= ld_be_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({enq, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Write drain only starts while the read side is idle, and a read only starts once the
  // buffer is empty and no write is in flight, so the two never request together.
  always_comb begin
    w_d = w_q;
    case (w_q)
      W_IDLE:  if (cnt_q != '0 && rd_q == RD_IDLE) w_d = W_REQ;
      W_REQ:   if (ucb.ucb_addr_ok) w_d = W_WAIT;
      W_WAIT:  if (ucb.ucb_data_ok) w_d = W_IDLE;
      default: w_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_d      = rd_q;
    ld_addr_d = ld_addr_q;
    ld_be_d   = ld_be_q;
    rdata_d   = rdata_q;
    case (rd_q)
      RD_IDLE: begin
        if (pres_ld) begin
          ld_addr_d = Phsy_Daddr;
          ld_be_d   = MEM_ByteEn;
          if (cnt_q == '0 && w_q == W_IDLE) rd_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (ucb.ucb_addr_ok) rd_d = MEM_Flush ? RD_DISCARD : RD_WAIT;
        else if (MEM_Flush)  rd_d = RD_IDLE;
      end
      RD_WAIT: begin
        if (ucb.ucb_data_ok) begin
          if (MEM_Flush) begin
            rd_d = RD_IDLE;
          end else begin
            rdata_d = ucb.ucb_rdata;
            rd_d    = RD_DONE;
          end
        end else if (MEM_Flush) begin
          rd_d = RD_DISCARD;
        end
      end
      RD_DONE:    rd_d = RD_IDLE;
      RD_DISCARD: if (ucb.ucb_data_ok) rd_d = RD_IDLE;
      default:    rd_d = RD_IDLE;
    endcase
  end

  always_comb begin
    ucb.ucb_req   = 1'b0;
    ucb.ucb_wr    = 1'b0;
    ucb.ucb_addr  = '0;
    ucb.ucb_wdata = '0;
    ucb.ucb_wstrb = '0;
    if (w_q == W_REQ) begin
      ucb.ucb_req   = 1'b1;
      ucb.ucb_wr    = 1'b1;
      ucb.ucb_addr  = head.addr;
      ucb.ucb_wdata = head.wdata;
      ucb.ucb_wstrb = head.wstrb;
    end else if (rd_q == RD_REQ) begin
      ucb.ucb_req   = 1'b1;
      ucb.ucb_addr  = ld_addr_q;
      ucb.ucb_wstrb = ld_be_q;
    end
  end
endmodule
